key_event_scheduler: RTL and testbench
======================================

Name: key_event_scheduler

Overview:
- Sits between the keypad scanner/debouncer and the rest of the system; the scanner supplies a 5-bit key code with a ready flag and a readn acknowledge input.
- Sequences the scanner handshake: captures each key code, drives readn low until the scanner clears ready, and queues the code in a small FIFO.
- Shares the queued key events between two requesters (port 0 = CPU, port 1 = display/debug) with round-robin arbitration, one code per grant.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32.
- CODE_W, 5, key code width.
- ACK_MIN, 16, minimum clk cycles readn is held low; covers one scanner slow-clock edge (clk/8) with margin.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- key_ready  in  1  scanner has a valid code
- key_code  in  CODE_W  scanner key code; valid while key_ready=1
- readn  out  1  acknowledge to scanner; active low
- req  in  2  read request per port, level-sensitive
- grant  out  2  one-hot, one-cycle pulse: the port that receives rd_code
- rd_valid  out  1  equals |grant
- rd_code  out  CODE_W  popped code; valid only when rd_valid=1
- count  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky: a key was dropped because the FIFO was full
- clr_ovf  in  1  clears overflow

Behaviour:
- Reset (async, active-high), all registers immediately: readn=1, grant=0, rd_valid=0, rd_code=0, count=0, overflow=0, FIFO pointers=0, capture FSM=IDLE, round-robin pointer favours port 0.
- Capture FSM states: IDLE, ACK, RELEASE.
  - IDLE: if key_ready=1, push key_code this cycle and go to ACK with the ack counter cleared. If the FIFO is full and no pop occurs in the same cycle, drop the code, set overflow, and still go to ACK.
  - ACK: readn=0. The ack counter increments each cycle. Go to RELEASE when counter ≥ ACK_MIN−1 and key_ready=0. If key_ready stays 1, remain in ACK indefinitely.
  - RELEASE: readn=1 for one cycle, then IDLE. This guarantees readn returns high before the next capture.
  - readn is registered; it first goes low in the cycle after capture.
  - A key is pushed exactly once per IDLE→ACK transition.
- Read arbitration:
  - Evaluated each cycle when count>0, or when a push occurs in the same cycle.
  - Popping uses the pre-push head only; there is no bypass. A push into an empty FIFO is grantable the following cycle.
  - If exactly one req bit is set, grant that port. If both are set, grant the port not granted last; the pointer flips to the other port after each grant.
  - grant, rd_valid and rd_code are registered: the grant appears the cycle after req is sampled. The pop takes effect in the same edge.
  - Back-to-back grants are allowed each cycle while the FIFO is non-empty and req is held.
  - A requester must drop req the cycle after its grant if it wants only one code.
  - Empty FIFO: no grant, rd_code holds its last value, rd_valid=0.
- Occupancy:
  - count_next = count + push − pop, where push means accepted.
  - Full with a simultaneous pop: the push is accepted and count is unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- overflow:
  - Set on a dropped push; cleared by clr_ovf.
  - Set takes priority over clear in the same cycle.
- Reset mid-handshake: FSM returns to IDLE with readn=1. A code still presented by the scanner is re-captured after reset.

Decomposition:
- Shared package key_pkg: CODE_W constant, capture FSM state enum (IDLE/ACK/RELEASE), port index constants PORT_CPU=0 and PORT_DISP=1.
- Sub-module key_fifo: synchronous FIFO with async active-high reset.
  - Ports: clk, rst, push, din, pop, dout, count, full, empty.
  - Parameterised by DEPTH and CODE_W.
  - The scheduler instantiates one key_fifo and contains the FSM and arbiter.

Test Plan:
- Single key: key_ready=1 with key_code=5'h07, held 12 cycles then dropped. Required: readn=0 from cycle +1 for 16 cycles, then 1; count=1. Then req=2'b01: grant=01, rd_code=07 the next cycle; count=0.
- Slow release: key_ready held 40 cycles. Required: readn stays 0 until the cycle after key_ready falls, then RELEASE for one cycle; exactly one push.
- Round-robin: queue codes 01, 02, 03, 04 and hold req=2'b11. Required: grants 01, 10, 01, 10 on consecutive cycles, rd_code=01, 02, 03, 04; then no grant with count=0.
- Overflow: push 9 codes (0x00..0x08) with no reads. Required: count=8, overflow=1, reads return 0x00..0x07. clr_ovf=1 → overflow=0.
- Full + simultaneous: at count=8 with req=01 held, capture a new key in the pop cycle. Required: count stays 8, overflow stays 0, the new code is read last.
- Reset mid-ACK: assert rst while readn=0. Required: readn=1, count=0 and grant=0 immediately. After release with key_ready still 1, one fresh capture occurs.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the keypad event scheduler: code width,
// capture handshake states and requester port indices.
package key_pkg;

    localparam int CODE_W    = 5;
    localparam int PORT_CPU  = 0;
    localparam int PORT_DISP = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        RELEASE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding captured key codes. dout shows the
// current head combinationally; push and pop may occur in the same cycle,
// including when full (the write lands in the slot being vacated).
module key_fifo
    import key_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int CODE_W = 5,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [CODE_W-1:0] din,
    input  logic              pop,
    output logic [CODE_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_event_scheduler.sv
// Keypad event scheduler: runs the scanner ready/readn handshake, queues
// captured codes and hands them out round-robin to two requesters.
//
// state   | meaning
// IDLE    | waiting for key_ready; captures the code on the cycle it is seen
// ACK     | readn held low for at least ACK_MIN cycles and until ready drops
// RELEASE | readn back high for one cycle before another capture is allowed
module key_event_scheduler
    import key_pkg::*;
#(
    parameter  int DEPTH   = 8,
    parameter  int CODE_W  = key_pkg::CODE_W,
    parameter  int ACK_MIN = 16,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int KW      = $clog2(ACK_MIN) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_ready,
    input  logic [CODE_W-1:0] key_code,
    output logic              readn,
    input  logic [1:0]        req,
    output logic [1:0]        grant,
    output logic              rd_valid,
    output logic [CODE_W-1:0] rd_code,
    output logic [CW-1:0]     count,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [KW-1:0] ACK_LAST = KW'(ACK_MIN - 1);

    cap_state_e        state_q, state_d;
    logic [KW-1:0]     ack_cnt_q, ack_cnt_d;
    logic              readn_q;
    logic [1:0]        grant_q, grant_d;
    logic              rr_q, rr_d;
    logic [CODE_W-1:0] rd_code_q, rd_code_d;
    logic              ovf_q, ovf_d;
    logic              cap_push;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic [CODE_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    key_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .din   (key_code),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Capture handshake: one push per IDLE->ACK, counter saturates so a
    // stuck key_ready cannot wrap it.
    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        cap_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_ready) begin
                    cap_push  = 1'b1;
                    ack_cnt_d = '0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (ack_cnt_q != ACK_LAST) begin
                    ack_cnt_d = ack_cnt_q + KW'(1);
                end
                if ((ack_cnt_q >= ACK_LAST) && !key_ready) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Round-robin arbiter over the pre-push head; rr_q=1 favours the display port.
    always_comb begin
        grant_d = 2'b00;
        if (!fifo_empty) begin
            case (req)
                2'b01:   grant_d[PORT_CPU]  = 1'b1;
                2'b10:   grant_d[PORT_DISP] = 1'b1;
                2'b11:   grant_d = rr_q ? 2'b10 : 2'b01;
                default: grant_d = 2'b00;
            endcase
        end
        pop       = |grant_d;
        rr_d      = grant_d[PORT_CPU] ? 1'b1 : (grant_d[PORT_DISP] ? 1'b0 : rr_q);
        rd_code_d = pop ? fifo_dout : rd_code_q;
        push_ok   = cap_push && (!fifo_full || pop);
        drop      = cap_push && fifo_full && !pop;
        ovf_d     = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    // Registered state, handshake output and read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ack_cnt_q <= '0;
            readn_q   <= 1'b1;
            grant_q   <= 2'b00;
            rr_q      <= 1'b0;
            rd_code_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
            readn_q   <= (state_d != ACK);
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            rd_code_q <= rd_code_d;
            ovf_q     <= ovf_d;
        end
    end

    assign readn    = readn_q;
    assign grant    = grant_q;
    assign rd_valid = |grant_q;
    assign rd_code  = rd_code_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;

    localparam int DEPTH   = 8;
    localparam int CODE_W  = 5;
    localparam int ACK_MIN = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              key_ready;
    logic [CODE_W-1:0] key_code;
    logic              readn;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              rd_valid;
    logic [CODE_W-1:0] rd_code;
    logic [3:0]        count;
    logic              overflow;
    logic              clr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_event_scheduler #(
        .DEPTH   (DEPTH),
        .CODE_W  (CODE_W),
        .ACK_MIN (ACK_MIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_ready (key_ready),
        .key_code  (key_code),
        .readn     (readn),
        .req       (req),
        .grant     (grant),
        .rd_valid  (rd_valid),
        .rd_code   (rd_code),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scanner side: drop ready, wait for readn to return high, then one idle cycle.
    task automatic finish_handshake();
        int budget;
        budget = 200;
        key_ready = 1'b0;
        while (readn !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        n_checks++;
        if (readn !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake_timeout readn=%b required 1", readn);
        end
        tick();
    endtask

    task automatic push_key(input logic [CODE_W-1:0] code);
        key_ready = 1'b1;
        key_code  = code;
        tick();
        finish_handshake();
    endtask

    task automatic test_reset();
        rst = 1'b1; key_ready = 1'b0; key_code = '0; req = 2'b00; clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({readn, grant, rd_valid, rd_code, count, overflow} !== {1'b1, 2'b00, 1'b0, 5'h00, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state readn=%b grant=%b rd_valid=%b rd_code=%h count=%0d ovf=%b required 1 00 0 00 0 0",
                     readn, grant, rd_valid, rd_code, count, overflow);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_key();
        key_ready = 1'b1;
        key_code  = 5'h07;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_checks++;
            if (readn !== 1'b0) begin
                n_fail++;
                $display("FAIL single_readn_low cycle=%0d readn=%b required 0", i, readn);
            end
            if (i == 11) key_ready = 1'b0;
        end
        tick();
        n_checks++;
        if (readn !== 1'b1) begin
            n_fail++;
            $display("FAIL single_readn_release readn=%b required 1", readn);
        end
        n_checks++;
        if (count !== 4'd1) begin
            n_fail++;
            $display("FAIL single_count count=%0d required 1", count);
        end
        tick();
        req = 2'b01;
        tick();
        req = 2'b00;
        n_checks++;
        if ({grant, rd_valid, rd_code, count} !== {2'b01, 1'b1, 5'h07, 4'd0}) begin
            n_fail++;
            $display("FAIL single_read grant=%b valid=%b code=%h count=%0d required 01 1 07 0",
                     grant, rd_valid, rd_code, count);
        end
        tick();
        n_checks++;
        if ({grant, rd_valid, rd_code} !== {2'b00, 1'b0, 5'h07}) begin
            n_fail++;
            $display("FAIL single_after grant=%b valid=%b code=%h required 00 0 07", grant, rd_valid, rd_code);
        end
    endtask

    task automatic test_slow_release();
        int low;
        low = 0;
        key_ready = 1'b1;
        key_code  = 5'h12;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (readn === 1'b0) low++;
        end
        key_ready = 1'b0;
        n_checks++;
        if (low != 40) begin
            n_fail++;
            $display("FAIL slow_low_cycles got=%0d required 40", low);
        end
        tick();
        n_checks++;
        if (readn !== 1'b1) begin
            n_fail++;
            $display("FAIL slow_release readn=%b required 1", readn);
        end
        tick();
        n_checks++;
        if ({readn, count} !== {1'b1, 4'd1}) begin
            n_fail++;
            $display("FAIL slow_one_push readn=%b count=%0d required 1 1", readn, count);
        end
        req = 2'b10;
        tick();
        req = 2'b00;
        n_checks++;
        if ({grant, rd_code, count} !== {2'b10, 5'h12, 4'd0}) begin
            n_fail++;
            $display("FAIL slow_read grant=%b code=%h count=%0d required 10 12 0", grant, rd_code, count);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] eg [4];
        eg[0] = 2'b01; eg[1] = 2'b10; eg[2] = 2'b01; eg[3] = 2'b10;
        for (int i = 1; i <= 4; i++) push_key(5'(i));
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({grant, rd_valid, rd_code} !== {eg[i], 1'b1, 5'(i + 1)}) begin
                n_fail++;
                $display("FAIL rr_grant idx=%0d grant=%b valid=%b code=%h required %b 1 %h",
                         i, grant, rd_valid, rd_code, eg[i], 5'(i + 1));
            end
        end
        tick();
        n_checks++;
        if ({grant, rd_valid, count} !== {2'b00, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL rr_empty grant=%b valid=%b count=%0d required 00 0 0", grant, rd_valid, count);
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= 8; i++) push_key(5'(i));
        n_checks++;
        if ({count, overflow} !== {4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_full count=%0d ovf=%b required 8 1", count, overflow);
        end
        req = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({grant, rd_code} !== {2'b01, 5'(i)}) begin
                n_fail++;
                $display("FAIL ovf_read idx=%0d grant=%b code=%h required 01 %h", i, grant, rd_code, 5'(i));
            end
        end
        req = 2'b00;
        tick();
        n_checks++;
        if ({count, overflow} !== {4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_sticky count=%0d ovf=%b required 0 1", count, overflow);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_full_simultaneous();
        logic [CODE_W-1:0] exp;
        for (int i = 0; i < 8; i++) push_key(5'(16 + i));
        n_checks++;
        if (count !== 4'd8) begin
            n_fail++;
            $display("FAIL fs_fill count=%0d required 8", count);
        end
        key_ready = 1'b1;
        key_code  = 5'h1F;
        req       = 2'b01;
        tick();
        req = 2'b00;
        n_checks++;
        if ({grant, rd_code, count, overflow} !== {2'b01, 5'h10, 4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL fs_pop_push grant=%b code=%h count=%0d ovf=%b required 01 10 8 0",
                     grant, rd_code, count, overflow);
        end
        finish_handshake();
        n_checks++;
        if ({count, overflow} !== {4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL fs_after count=%0d ovf=%b required 8 0", count, overflow);
        end
        req = 2'b01;
        for (int i = 0; i < 8; i++) begin
            exp = (i < 7) ? 5'(17 + i) : 5'h1F;
            tick();
            n_checks++;
            if ({grant, rd_code} !== {2'b01, exp}) begin
                n_fail++;
                $display("FAIL fs_read idx=%0d grant=%b code=%h required 01 %h", i, grant, rd_code, exp);
            end
        end
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_ack();
        push_key(5'h0B);
        key_ready = 1'b1;
        key_code  = 5'h0A;
        req       = 2'b10;
        tick();
        req = 2'b00;
        n_checks++;
        if ({readn, grant, rd_code, count} !== {1'b0, 2'b10, 5'h0B, 4'd1}) begin
            n_fail++;
            $display("FAIL rma_before readn=%b grant=%b code=%h count=%0d required 0 10 0b 1",
                     readn, grant, rd_code, count);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({readn, grant, rd_valid, count} !== {1'b1, 2'b00, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL rma_async readn=%b grant=%b valid=%b count=%0d required 1 00 0 0",
                     readn, grant, rd_valid, count);
        end
        #1 rst = 1'b0;
        tick();
        n_checks++;
        if ({readn, count} !== {1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL rma_recapture readn=%b count=%0d required 0 1", readn, count);
        end
        finish_handshake();
        n_checks++;
        if (count !== 4'd1) begin
            n_fail++;
            $display("FAIL rma_single count=%0d required 1", count);
        end
        req = 2'b01;
        tick();
        req = 2'b00;
        n_checks++;
        if ({grant, rd_code, count} !== {2'b01, 5'h0A, 4'd0}) begin
            n_fail++;
            $display("FAIL rma_read grant=%b code=%h count=%0d required 01 0a 0", grant, rd_code, count);
        end
        tick();
    endtask

    // Random scanner + requester traffic against a queue-based reference.
    task automatic test_random();
        logic [CODE_W-1:0] q[$];
        logic [CODE_W-1:0] exp_code;
        logic [1:0]        exp_grant;
        logic              exp_ovf;
        logic              exp_readn;
        int  last_port, port;
        bit  busy, push_now, drop;
        int  e, h, k, gap;

        rst = 1'b1; key_ready = 1'b0; req = 2'b00; clr_ovf = 1'b0;
        #2 rst = 1'b0;
        last_port = 1; exp_ovf = 1'b0; exp_code = '0;
        busy = 0; e = 0; h = 1; k = ACK_MIN; gap = 0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!busy) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    busy     = 1;
                    e        = 0;
                    h        = $urandom_range(1, 30);
                    k        = (h > ACK_MIN) ? h : ACK_MIN;
                    key_code = 5'($urandom);
                end
            end
            key_ready = busy && (e < h);
            push_now  = busy && (e == 0);
            req       = (((cyc / 300) % 2) == 1) ? 2'b00 : 2'($urandom);
            clr_ovf   = ($urandom_range(0, 39) == 0);

            exp_grant = 2'b00;
            port      = -1;
            if (q.size() > 0) begin
                if (req == 2'b01)      port = 0;
                else if (req == 2'b10) port = 1;
                else if (req == 2'b11) port = (last_port == 0) ? 1 : 0;
            end
            if (port >= 0) begin
                exp_code  = q.pop_front();
                last_port = port;
                exp_grant = (port == 0) ? 2'b01 : 2'b10;
            end
            drop = 0;
            if (push_now) begin
                if (q.size() < DEPTH) q.push_back(key_code);
                else drop = 1;
            end
            if (drop) exp_ovf = 1'b1;
            else if (clr_ovf) exp_ovf = 1'b0;
            exp_readn = busy ? ((e < k) ? 1'b0 : 1'b1) : 1'b1;

            tick();

            n_checks++;
            if ({grant, rd_valid} !== {exp_grant, |exp_grant}) begin
                n_fail++;
                $display("FAIL rand_grant cyc=%0d grant=%b valid=%b required %b %b",
                         cyc, grant, rd_valid, exp_grant, |exp_grant);
            end
            n_checks++;
            if (rd_code !== exp_code) begin
                n_fail++;
                $display("FAIL rand_code cyc=%0d code=%h required %h", cyc, rd_code, exp_code);
            end
            n_checks++;
            if (count !== 4'(q.size())) begin
                n_fail++;
                $display("FAIL rand_count cyc=%0d count=%0d required %0d", cyc, count, q.size());
            end
            n_checks++;
            if (overflow !== exp_ovf) begin
                n_fail++;
                $display("FAIL rand_ovf cyc=%0d ovf=%b required %b", cyc, overflow, exp_ovf);
            end
            n_checks++;
            if (readn !== exp_readn) begin
                n_fail++;
                $display("FAIL rand_readn cyc=%0d readn=%b required %b", cyc, readn, exp_readn);
            end

            if (busy) begin
                e++;
                if (e == k + 2) begin
                    busy = 0;
                    gap  = $urandom_range(0, 3);
                end
            end
        end
        key_ready = 1'b0;
        req       = 2'b00;
        clr_ovf   = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_slow_release();
        test_round_robin();
        test_overflow();
        test_full_simultaneous();
        test_reset_mid_ack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
